// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared state encoding, default widths and Gray conversion
// for the Gray sequencer.
package gray_pkg;

  localparam int W_DEF  = 4;
  localparam int SW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Callers size the argument and result to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// rtl/gray_seq_ctrl_if.sv - requester-facing run handshake, run control and
// Gray position signals of the sequencer.
interface gray_seq_ctrl_if
  import gray_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
);

  logic          req;
  logic [SW-1:0] steps;
  logic          dir;
  logic          hold;
  logic          abort;
  logic          ack;
  logic          busy;
  logic          done;
  logic [W-1:0]  qn;
  logic          err;

  modport master (
    output req, steps, dir, hold, abort,
    input  ack, busy, done, qn, err
  );

  modport slave (
    input  req, steps, dir, hold, abort,
    output ack, busy, done, qn, err
  );

endinterface

// File: rtl/gray_cnt_core.sv
// rtl/gray_cnt_core.sv - W-bit binary counter with step/direction enable and a
// registered Gray-code output updated on the step edge itself.
module gray_cnt_core
  import gray_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         dir,
  output logic [W-1:0] qn
);

  logic [W-1:0] bin;
  logic [W-1:0] bin_nxt;

  always_comb begin
    bin_nxt = dir ? (bin + W'(1)) : (bin - W'(1));
  end

  // qn takes the Gray code of the new value, so no XOR sits after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= '0;
      qn  <= '0;
    end else if (step) begin
      bin <= bin_nxt;
      qn  <= W'(bin2gray(32'(bin_nxt)));
    end
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - run-command FSM, handshake and remaining-step counter
// around gray_cnt_core; optional QN step checker under GRAY_SEQ_ERRCHK_EN.
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  gray_seq_ctrl_if.slave  bus
);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] remaining;
  logic [SW-1:0] remaining_nxt;
  logic          dir_q;
  logic          dir_nxt;
  logic          ack_q;
  logic          ack_nxt;
  logic          step;
  logic [W-1:0]  qn_core;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      dir_q     <= dir_nxt;
      ack_q     <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    dir_nxt       = dir_q;
    ack_nxt       = 1'b0;
    step          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          ack_nxt       = 1'b1;
          remaining_nxt = bus.steps;
          dir_nxt       = bus.dir;
          state_nxt     = (bus.steps != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        // Abort outranks both hold and the final step.
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (!bus.hold) begin
          step          = 1'b1;
          remaining_nxt = remaining - SW'(1);
          if (remaining == SW'(1)) begin
            state_nxt = FIN;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  gray_cnt_core #(
    .W (W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .dir   (dir_q),
    .qn    (qn_core)
  );

  assign bus.ack  = ack_q;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == FIN);
  assign bus.qn   = qn_core;

`ifdef GRAY_SEQ_ERRCHK_EN
  logic [W-1:0] qn_prev;
  logic         err_q;

  // Any change of the visible position must flip exactly one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qn_prev <= '0;
      err_q   <= 1'b0;
    end else begin
      qn_prev <= bus.qn;
      if ($countones(bus.qn ^ qn_prev) > 1) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
